// File: rtl/count_display.sv
// Two-digit multiplexed seven-segment reader for a 6-bit counter value.
// A load converts the value to BCD by shift-add-3, and a prescaler alternates the two digits.
module count_display #(
  parameter int SCAN_DIV = 50000,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic       clock,
  input  logic       rst,
  input  logic [5:0] count,
  input  logic       load,
  output logic       busy,
  output logic [6:0] seg,
  output logic [1:0] an
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          state_q, state_d;
  logic [5:0]      bin_q, bin_d;
  logic [6:0]      bcd_q, bcd_d;
  logic [2:0]      bitcnt_q, bitcnt_d;
  logic [3:0]      units_q, units_d;
  logic [2:0]      tens_q, tens_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic            sel_q, sel_d;
  logic [6:0]      seg_q, seg_d;
  logic [1:0]      an_q, an_d;
  logic [3:0]      units_adj;
  logic [2:0]      tens_adj;

  // Active-low patterns, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b100_0000;
      4'd1:    return 7'b111_1001;
      4'd2:    return 7'b010_0100;
      4'd3:    return 7'b011_0000;
      4'd4:    return 7'b001_1001;
      4'd5:    return 7'b001_0010;
      4'd6:    return 7'b000_0010;
      4'd7:    return 7'b111_1000;
      4'd8:    return 7'b000_0000;
      4'd9:    return 7'b001_0000;
      default: return 7'b111_1111;
    endcase
  endfunction

  always_comb begin
    state_d   = state_q;
    bin_d     = bin_q;
    bcd_d     = bcd_q;
    bitcnt_d  = bitcnt_q;
    units_d   = units_q;
    tens_d    = tens_q;
    units_adj = (bcd_q[3:0] >= 4'd5) ? bcd_q[3:0] + 4'd3 : bcd_q[3:0];
    tens_adj  = (bcd_q[6:4] >= 3'd5) ? bcd_q[6:4] + 3'd3 : bcd_q[6:4];
    case (state_q)
      IDLE: begin
        if (load) begin
          bin_d    = count;
          bcd_d    = '0;
          bitcnt_d = 3'd6;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        // The top tens bit cannot be set for a 6-bit input, so dropping it is safe.
        bcd_d    = 7'({tens_adj, units_adj, bin_q[5]});
        bin_d    = {bin_q[4:0], 1'b0};
        bitcnt_d = bitcnt_q - 3'd1;
        if (bitcnt_q == 3'd1) state_d = DONE;
      end
      DONE: begin
        units_d = bcd_q[3:0];
        tens_d  = bcd_q[6:4];
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    presc_d = presc_q;
    sel_d   = sel_q;
    seg_d   = seg_q;
    an_d    = an_q;
    if (presc_q == PW'(SCAN_DIV - 1)) begin
      presc_d = '0;
      sel_d   = ~sel_q;
      // sel_q names the digit shown in the slot starting now; it is units after reset.
      if (sel_q) begin
        an_d  = 2'b01;
        seg_d = (BLANK_LZ && tens_q == 3'd0) ? 7'b111_1111 : seg_code({1'b0, tens_q});
      end else begin
        an_d  = 2'b10;
        seg_d = seg_code(units_q);
      end
    end else begin
      presc_d = presc_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q  <= IDLE;
      bin_q    <= '0;
      bcd_q    <= '0;
      bitcnt_q <= '0;
      units_q  <= '0;
      tens_q   <= '0;
      presc_q  <= '0;
      sel_q    <= 1'b0;
      seg_q    <= 7'b111_1111;
      an_q     <= 2'b11;
    end else begin
      state_q  <= state_d;
      bin_q    <= bin_d;
      bcd_q    <= bcd_d;
      bitcnt_q <= bitcnt_d;
      units_q  <= units_d;
      tens_q   <= tens_d;
      presc_q  <= presc_d;
      sel_q    <= sel_d;
      seg_q    <= seg_d;
      an_q     <= an_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign seg  = seg_q;
  assign an   = an_q;

endmodule

// File: tb/tb_count_display.sv
// Bench for count_display: two instances (blanking on/off) share the stimulus;
// the displayed digits are compared against value/10 and value%10.
module tb_count_display;
  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       load;
  logic [5:0] count;
  logic       busy0, busy1;
  logic [6:0] seg0, seg1;
  logic [1:0] an0, an1;

  int vectors = 0;
  int miscompares = 0;

  logic [6:0] seg_tab [10] = '{7'b100_0000, 7'b111_1001, 7'b010_0100, 7'b011_0000,
                               7'b001_1001, 7'b001_0010, 7'b000_0010, 7'b111_1000,
                               7'b000_0000, 7'b001_0000};

  always #5 clk = ~clk;

  count_display #(.SCAN_DIV(DIV), .BLANK_LZ(1'b1)) dut_blank (
    .clock(clk), .rst(rst), .count(count), .load(load),
    .busy(busy0), .seg(seg0), .an(an0)
  );

  count_display #(.SCAN_DIV(DIV), .BLANK_LZ(1'b0)) dut_zero (
    .clock(clk), .rst(rst), .count(count), .load(load),
    .busy(busy1), .seg(seg1), .an(an1)
  );

  function automatic logic [6:0] exp_units(input int v);
    return seg_tab[v % 10];
  endfunction

  function automatic logic [6:0] exp_tens(input int v, input bit blank);
    if (blank && (v / 10) == 0) return 7'b111_1111;
    return seg_tab[v / 10];
  endfunction

  task automatic do_load(input logic [5:0] v);
    @(negedge clk);
    count = v;
    load  = 1'b1;
    @(posedge clk);
    #1;
    load = 1'b0;
  endtask

  // Counts edges until busy drops, starting just after the accepting edge.
  task automatic wait_idle(output int n);
    n = 0;
    while (busy0 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  // Captures the segment pattern of each slot from scan wraps occurring after the call.
  task automatic read_display(input bit which, output logic [6:0] u, output logic [6:0] t,
                              output bit ok);
    logic [1:0] prev, cur;
    bit got_u, got_t;
    got_u = 0;
    got_t = 0;
    u = 'x;
    t = 'x;
    @(negedge clk);
    prev = which ? an1 : an0;
    for (int k = 0; k < 40 && !(got_u && got_t); k++) begin
      @(negedge clk);
      cur = which ? an1 : an0;
      if (cur !== prev) begin
        if (cur == 2'b10) begin u = which ? seg1 : seg0; got_u = 1; end
        if (cur == 2'b01) begin t = which ? seg1 : seg0; got_t = 1; end
        prev = cur;
      end
    end
    ok = got_u && got_t;
  endtask

  task automatic test_reset;
    rst   = 1'b1;
    load  = 1'b0;
    count = '0;
    repeat (2) @(posedge clk);
    #1;
    vectors++; if (seg0 !== 7'b111_1111) begin miscompares++; $display("FAIL reset_seg: got %b expected 1111111", seg0); end
    vectors++; if (an0 !== 2'b11) begin miscompares++; $display("FAIL reset_an: got %b expected 11", an0); end
    vectors++; if (busy0 !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy0); end
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++; if (an0 !== 2'b11) begin miscompares++; $display("FAIL prewrap_an: got %b expected 11", an0); end
    @(posedge clk);
    #1;
    vectors++; if (an0 !== 2'b10 || seg0 !== seg_tab[0]) begin
      miscompares++; $display("FAIL first_wrap: got an=%b seg=%b expected an=10 seg=%b", an0, seg0, seg_tab[0]);
    end
    repeat (DIV) @(posedge clk);
    #1;
    vectors++; if (an0 !== 2'b01 || seg0 !== 7'b111_1111) begin
      miscompares++; $display("FAIL tens_blank: got an=%b seg=%b expected an=01 seg=1111111", an0, seg0);
    end
    vectors++; if (an1 !== 2'b01 || seg1 !== seg_tab[0]) begin
      miscompares++; $display("FAIL tens_zero: got an=%b seg=%b expected an=01 seg=%b", an1, seg1, seg_tab[0]);
    end
  endtask

  task automatic test_convert_47;
    int n;
    logic [6:0] u, t;
    bit ok;
    do_load(6'd47);
    vectors++; if (busy0 !== 1'b1) begin miscompares++; $display("FAIL busy_rise: got %b expected 1", busy0); end
    wait_idle(n);
    vectors++; if (n != 7) begin miscompares++; $display("FAIL busy_len_47: got %0d expected 7", n); end
    read_display(1'b0, u, t, ok);
    vectors++; if (!ok || u !== seg_tab[7] || t !== seg_tab[4]) begin
      miscompares++; $display("FAIL disp_47: got ok=%0d u=%b t=%b expected u=%b t=%b", ok, u, t, seg_tab[7], seg_tab[4]);
    end
  endtask

  // Every value once, in shuffled order, with count scrambled while shifting.
  task automatic test_sweep;
    int order [64];
    int j, tmp, n, v;
    bit which, ok;
    logic [6:0] u, t;
    for (int i = 0; i < 64; i++) order[i] = i;
    for (int i = 63; i > 0; i--) begin
      j = $urandom_range(0, i);
      tmp = order[i]; order[i] = order[j]; order[j] = tmp;
    end
    for (int i = 0; i < 64; i++) begin
      v = order[i];
      which = 1'($urandom);
      do_load(6'(v));
      count = 6'($urandom);
      wait_idle(n);
      vectors++; if (n != 7) begin miscompares++; $display("FAIL sweep_latency v=%0d: got %0d expected 7", v, n); end
      read_display(which, u, t, ok);
      vectors++; if (!ok || u !== exp_units(v)) begin
        miscompares++; $display("FAIL sweep_units v=%0d dut=%0d: got %b expected %b", v, which, u, exp_units(v));
      end
      vectors++; if (!ok || t !== exp_tens(v, !which)) begin
        miscompares++; $display("FAIL sweep_tens v=%0d dut=%0d: got %b expected %b", v, which, t, exp_tens(v, !which));
      end
    end
  endtask

  task automatic test_ignored_load;
    int n;
    logic [6:0] u, t;
    bit ok;
    do_load(6'd63);
    repeat (3) @(negedge clk);
    count = 6'd12;
    load  = 1'b1;
    @(posedge clk);
    #1;
    load = 1'b0;
    wait_idle(n);
    vectors++; if (n != 4) begin miscompares++; $display("FAIL ignore_busy: got %0d more edges expected 4", n); end
    read_display(1'b0, u, t, ok);
    vectors++; if (!ok || u !== exp_units(63) || t !== exp_tens(63, 1)) begin
      miscompares++; $display("FAIL ignore_disp: got u=%b t=%b expected u=%b t=%b", u, t, exp_units(63), exp_tens(63, 1));
    end
    do_load(6'd12);
    wait_idle(n);
    read_display(1'b0, u, t, ok);
    vectors++; if (!ok || u !== exp_units(12) || t !== exp_tens(12, 1)) begin
      miscompares++; $display("FAIL reload_disp: got u=%b t=%b expected u=%b t=%b", u, t, exp_units(12), exp_tens(12, 1));
    end
  endtask

  task automatic test_reset_mid;
    do_load(6'd58);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    vectors++; if (busy0 !== 1'b0 || an0 !== 2'b11 || seg0 !== 7'b111_1111) begin
      miscompares++; $display("FAIL midreset_out: got busy=%b an=%b seg=%b expected 0 11 1111111", busy0, an0, seg0);
    end
    repeat (DIV - 1) @(posedge clk);
    #1;
    vectors++; if (an0 !== 2'b11) begin miscompares++; $display("FAIL midreset_prewrap: got %b expected 11", an0); end
    @(posedge clk);
    #1;
    vectors++; if (an0 !== 2'b10 || seg0 !== seg_tab[0]) begin
      miscompares++; $display("FAIL midreset_units: got an=%b seg=%b expected an=10 seg=%b", an0, seg0, seg_tab[0]);
    end
    repeat (DIV) @(posedge clk);
    #1;
    vectors++; if (an0 !== 2'b01 || seg0 !== 7'b111_1111) begin
      miscompares++; $display("FAIL midreset_tens: got an=%b seg=%b expected an=01 seg=1111111", an0, seg0);
    end
  endtask

  task automatic test_no_blank;
    int v, n;
    logic [6:0] u, t;
    bit ok;
    for (int k = 0; k < 2; k++) begin
      v = (k == 0) ? 5 : int'($urandom_range(0, 9));
      do_load(6'(v));
      wait_idle(n);
      read_display(1'b1, u, t, ok);
      vectors++; if (!ok || t !== seg_tab[0] || u !== seg_tab[v]) begin
        miscompares++; $display("FAIL noblank v=%0d: got u=%b t=%b expected u=%b t=%b", v, u, t, seg_tab[v], seg_tab[0]);
      end
      read_display(1'b0, u, t, ok);
      vectors++; if (!ok || t !== 7'b111_1111 || u !== seg_tab[v]) begin
        miscompares++; $display("FAIL blank v=%0d: got u=%b t=%b expected u=%b t=1111111", v, u, t, seg_tab[v]);
      end
    end
  endtask

  initial begin
    test_reset;
    test_convert_47;
    test_sweep;
    test_ignored_load;
    test_reset_mid;
    test_no_blank;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
